ibex_trace_capture: RTL and testbench
=====================================

Name: ibex_trace_capture

Overview:
On-chip retirement trace buffer for the tracing top level. It captures retired-instruction records (pc, insn, rd address, rd write data) from the core's RVFI retirement port into a parametrised circular buffer. Three capture modes: fill-stop, wrap (keep newest), and PC-triggered with pre/post-trigger history. Contents drain through a valid/ready read port to a debug or trace-export block.

Parameters:
Depth, 16, number of records; power of two, >= 2
XLen, 32, width of pc and rd write data
PostCntW, $clog2(Depth)+1, width of the post-trigger count input

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
mode_i  in  2  trace_mode_e: 00 OFF, 01 FILL, 10 WRAP, 11 TRIG
clear_i  in  1  empty buffer, clear flags, return to IDLE
trig_pc_i  in  XLen  trigger PC (TRIG mode)
post_cnt_i  in  PostCntW  records captured after the trigger record
rvfi_valid_i  in  1  retirement strobe
rvfi_pc_i  in  XLen  retired pc
rvfi_insn_i  in  32  retired instruction
rvfi_rd_addr_i  in  5  destination register
rvfi_rd_wdata_i  in  XLen  destination write data
rd_valid_o  out  1  oldest record available
rd_ready_i  in  1  reader accepts record
rd_data_o  out  2*XLen+37  oldest record {pc, insn, rd_addr, rd_wdata}, first-word-fall-through
level_o  out  $clog2(Depth)+1  records held, 0..Depth
overflow_o  out  1  sticky: a record was dropped or overwritten
triggered_o  out  1  sticky: trigger PC seen
done_o  out  1  high in FROZEN

Behaviour:
- Reset (rst_ni low at a clk_i edge): state IDLE, pointers 0, level_o=0, rd_valid_o=0, overflow_o=0, triggered_o=0, done_o=0. Storage contents are don't-care.
- Reset mid-operation discards all records. No partial state survives.
- States: IDLE, CAPTURE, ARMED, FROZEN. The mode register is latched only on leaving IDLE.
- IDLE: no writes. mode_i FILL/WRAP -> CAPTURE; TRIG -> ARMED; OFF -> stay.
- In any non-IDLE state, mode_i==OFF -> IDLE next cycle. Contents are retained and remain readable.
- clear_i has highest priority in every state: next cycle pointers=0, flags=0, state IDLE.
- Write occurs when rvfi_valid_i and state is CAPTURE or ARMED. A record is visible on rd_data_o the cycle after its write.
- Pop occurs when rd_valid_o && rd_ready_i. rd_valid_o = (level_o != 0). Reads are permitted in every state.
- Full-buffer write, FILL mode: new record dropped, overflow_o set, level unchanged. If a pop happens the same cycle, the write is accepted (net level unchanged).
- Full-buffer write, WRAP or ARMED: oldest record overwritten (read pointer advances), overflow_o set. A simultaneous pop is absorbed by the same advance: level stays Depth and only one oldest entry leaves.
- Non-full write plus pop in the same cycle: level unchanged.
- Pointers are log2(Depth) bits and wrap naturally. level_o is tracked separately.
- ARMED: pre-trigger history is kept WRAP-style. When rvfi_pc_i==trig_pc_i on a valid retirement, that record is written, triggered_o is set and the post counter loads post_cnt_i.
  - post_cnt_i==0 -> FROZEN next cycle.
  - post_cnt_i>0 -> CAPTURE (trig sub-mode).
- CAPTURE in TRIG mode: each write decrements the counter (overwrite-oldest on full). The write that brings the counter to 0 is stored, then FROZEN.
- Trigger matches in CAPTURE/FROZEN are ignored.
- FROZEN: no writes, done_o=1. Exit only via clear_i or mode_i==OFF.
- post_cnt_i values above Depth are legal; older records are simply overwritten.

Decomposition:
- ibex_pkg: trace_mode_e (2-bit enum), trace_rec_t packed struct, trace_state_e.
- Sub-module ibex_trace_fifo holds storage, pointers, level, and full/empty. It has push, pop and overwrite-enable inputs.
- ibex_trace_capture holds the FSM, trigger compare, post counter and sticky flags.

Test Plan:
(All with Depth=4.)
- FILL: 6 retirements pc 0x100..0x114, no reads -> level_o=4, records 0x100..0x10C, overflow_o=1. Drain returns the 4 records in order, then rd_valid_o=0.
- WRAP: 6 retirements pc 0x100..0x114 -> level_o=4, drain yields 0x108,0x10C,0x110,0x114, overflow_o=1.
- TRIG, trig_pc=0x200, post_cnt=2, retire 0x1F0,0x1F4,0x200,0x204,0x208,0x20C -> triggered_o=1, done_o=1, drain yields 0x1F4,0x200,0x204,0x208.
- TRIG, post_cnt=0, trigger on the first retirement 0x200 -> FROZEN the next cycle, level_o=1, later retirements ignored.
- Simultaneous push+pop at level 4 in WRAP, rd_ready held high with continuous retirements for 10 cycles -> level_o stays 4, every popped pc is strictly increasing.
- clear_i and synchronous reset asserted mid-CAPTURE at level 3 -> next cycle level_o=0, all flags 0, state IDLE, rd_valid_o=0.

Source files
------------

// File: rtl/ibex_trace_capture_pkg.sv
// Shared types for the retirement trace capture buffer.
package ibex_trace_capture_pkg;

    localparam int unsigned TRACE_XLEN = 32;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_FILL = 2'b01,
        MODE_WRAP = 2'b10,
        MODE_TRIG = 2'b11
    } trace_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_ARMED   = 2'b10,
        ST_FROZEN  = 2'b11
    } trace_state_e;

    // Record layout as presented on rd_data_o for the default XLen.
    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [31:0]           insn;
        logic [4:0]            rd_addr;
        logic [TRACE_XLEN-1:0] rd_wdata;
    } trace_rec_t;

endpackage

// File: rtl/ibex_trace_fifo.sv
// Circular record store with drop-on-full or overwrite-oldest writes and a
// registered first-word-fall-through read port.
module ibex_trace_fifo #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 101
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     ovr_en,
    input  logic [Width-1:0]         wdata,
    output logic [Width-1:0]         rdata,
    output logic                     valid,
    output logic [$clog2(Depth):0]   level,
    output logic                     lost_c
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic [Width-1:0] rdata_q, rdata_d;
    logic             valid_q;
    logic             full, pop_ok, wr_en;

    // Pointer/level update; a full write either drops, overwrites, or rides a pop.
    always_comb begin
        full    = (level_q == LvlW'(Depth));
        pop_ok  = pop && (level_q != '0);
        wr_en   = 1'b0;
        lost_c  = 1'b0;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push && full) begin
            if (ovr_en) begin
                wr_en  = 1'b1;
                lost_c = 1'b1;
                wptr_d = wptr_q + PtrW'(1);
                rptr_d = rptr_q + PtrW'(1);
            end else if (pop_ok) begin
                wr_en  = 1'b1;
                wptr_d = wptr_q + PtrW'(1);
                rptr_d = rptr_q + PtrW'(1);
            end else begin
                lost_c = 1'b1;
            end
        end else if (push) begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + PtrW'(1);
            if (pop_ok) begin
                rptr_d = rptr_q + PtrW'(1);
            end else begin
                level_d = level_q + LvlW'(1);
            end
        end else if (pop_ok) begin
            rptr_d  = rptr_q + PtrW'(1);
            level_d = level_q - LvlW'(1);
        end
        if (clear) begin
            wr_en   = 1'b0;
            lost_c  = 1'b0;
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end
        // Next head record, bypassing a write landing in the head slot.
        rdata_d = (wr_en && (wptr_q == rptr_d)) ? wdata : mem[rptr_d];
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            valid_q <= (level_d != '0);
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    assign valid = valid_q;
    assign level = level_q;

endmodule

// File: rtl/ibex_trace_capture.sv
// Retirement trace capture: mode FSM, PC trigger with post-trigger count,
// sticky status flags, around a circular record buffer.
module ibex_trace_capture
    import ibex_trace_capture_pkg::*;
#(
    parameter int unsigned Depth    = 16,
    parameter int unsigned XLen     = 32,
    parameter int unsigned PostCntW = $clog2(Depth) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [1:0]              mode_i,
    input  logic                    clear_i,
    input  logic [XLen-1:0]         trig_pc_i,
    input  logic [PostCntW-1:0]     post_cnt_i,
    input  logic                    rvfi_valid_i,
    input  logic [XLen-1:0]         rvfi_pc_i,
    input  logic [31:0]             rvfi_insn_i,
    input  logic [4:0]              rvfi_rd_addr_i,
    input  logic [XLen-1:0]         rvfi_rd_wdata_i,
    output logic                    rd_valid_o,
    input  logic                    rd_ready_i,
    output logic [2*XLen+36:0]      rd_data_o,
    output logic [$clog2(Depth):0]  level_o,
    output logic                    overflow_o,
    output logic                    triggered_o,
    output logic                    done_o
);

    localparam int unsigned RecW = 2 * XLen + 37;

    trace_state_e          state_q, state_d;
    trace_mode_e           mode_q, mode_d;
    logic [PostCntW-1:0]   cnt_q, cnt_d;
    logic                  overflow_q, overflow_d;
    logic                  triggered_q, triggered_d;
    logic                  done_q, done_d;
    logic                  push, ovr_en, hit, lost;
    logic [RecW-1:0]       rec;

    assign rec = {rvfi_pc_i, rvfi_insn_i, rvfi_rd_addr_i, rvfi_rd_wdata_i};

    // Next-state, post counter and sticky flag logic.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        overflow_d  = overflow_q | lost;
        triggered_d = triggered_q;
        push        = rvfi_valid_i && ((state_q == ST_CAPTURE) || (state_q == ST_ARMED));
        ovr_en      = (mode_q != MODE_FILL);
        hit         = push && (state_q == ST_ARMED) && (rvfi_pc_i == trig_pc_i);
        unique case (state_q)
            ST_IDLE: begin
                if (mode_i != MODE_OFF) begin
                    mode_d  = trace_mode_e'(mode_i);
                    state_d = (mode_i == MODE_TRIG) ? ST_ARMED : ST_CAPTURE;
                end
            end
            ST_ARMED: begin
                if (hit) begin
                    triggered_d = 1'b1;
                    cnt_d       = post_cnt_i;
                    state_d     = (post_cnt_i == '0) ? ST_FROZEN : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (push && (mode_q == MODE_TRIG)) begin
                    cnt_d = cnt_q - PostCntW'(1);
                    if (cnt_q <= PostCntW'(1)) begin
                        state_d = ST_FROZEN;
                    end
                end
            end
            default: ;
        endcase
        if ((state_q != ST_IDLE) && (mode_i == MODE_OFF)) begin
            state_d = ST_IDLE;
        end
        if (clear_i) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            overflow_d  = 1'b0;
            triggered_d = 1'b0;
        end
        done_d = (state_d == ST_FROZEN);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_OFF;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            overflow_q  <= overflow_d;
            triggered_q <= triggered_d;
            done_q      <= done_d;
        end
    end

    ibex_trace_fifo #(
        .Depth (Depth),
        .Width (RecW)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear  (clear_i),
        .push   (push),
        .pop    (rd_ready_i),
        .ovr_en (ovr_en),
        .wdata  (rec),
        .rdata  (rd_data_o),
        .valid  (rd_valid_o),
        .level  (level_o),
        .lost_c (lost)
    );

    assign overflow_o  = overflow_q;
    assign triggered_o = triggered_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_ibex_trace_capture.sv
// Directed bench for ibex_trace_capture at Depth=4.
module tb_ibex_trace_capture;
    import ibex_trace_capture_pkg::*;

    localparam int unsigned Depth    = 4;
    localparam int unsigned XLen     = 32;
    localparam int unsigned PostCntW = 3;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic [1:0]          mode_i;
    logic                clear_i;
    logic [XLen-1:0]     trig_pc_i;
    logic [PostCntW-1:0] post_cnt_i;
    logic                rvfi_valid_i;
    logic [XLen-1:0]     rvfi_pc_i;
    logic [31:0]         rvfi_insn_i;
    logic [4:0]          rvfi_rd_addr_i;
    logic [XLen-1:0]     rvfi_rd_wdata_i;
    logic                rd_valid_o;
    logic                rd_ready_i;
    logic [2*XLen+36:0]  rd_data_o;
    logic [2:0]          level_o;
    logic                overflow_o;
    logic                triggered_o;
    logic                done_o;

    int n_cmp = 0;
    int n_err = 0;

    trace_rec_t rec;
    assign rec = trace_rec_t'(rd_data_o);

    always #5 clk_i = ~clk_i;

    ibex_trace_capture #(
        .Depth    (Depth),
        .XLen     (XLen),
        .PostCntW (PostCntW)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .mode_i          (mode_i),
        .clear_i         (clear_i),
        .trig_pc_i       (trig_pc_i),
        .post_cnt_i      (post_cnt_i),
        .rvfi_valid_i    (rvfi_valid_i),
        .rvfi_pc_i       (rvfi_pc_i),
        .rvfi_insn_i     (rvfi_insn_i),
        .rvfi_rd_addr_i  (rvfi_rd_addr_i),
        .rvfi_rd_wdata_i (rvfi_rd_wdata_i),
        .rd_valid_o      (rd_valid_o),
        .rd_ready_i      (rd_ready_i),
        .rd_data_o       (rd_data_o),
        .level_o         (level_o),
        .overflow_o      (overflow_o),
        .triggered_o     (triggered_o),
        .done_o          (done_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_rec(input logic [31:0] pc);
        rvfi_pc_i       = pc;
        rvfi_insn_i     = {16'hA5A5, pc[15:0]};
        rvfi_rd_addr_i  = pc[6:2];
        rvfi_rd_wdata_i = ~pc;
    endtask

    // Back-to-back retirements pc, pc+4, ...
    task automatic retire(input logic [31:0] pc, input int n);
        for (int i = 0; i < n; i++) begin
            rvfi_valid_i = 1'b1;
            set_rec(pc + 32'(4 * i));
            step();
        end
        rvfi_valid_i = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, 64'(rd_valid_o), 64'd1);
        check({tag, "_pc"}, 64'(rec.pc), 64'(pc));
        rd_ready_i = 1'b1;
        step();
        rd_ready_i = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; mode_i = MODE_OFF; clear_i = 1'b0;
        trig_pc_i = '0; post_cnt_i = '0; rvfi_valid_i = 1'b0;
        set_rec(32'h0); rd_ready_i = 1'b0;
        step(); step();
        rst_ni = 1'b1;
        check("rst_level", 64'(level_o), 64'd0);
        check("rst_valid", 64'(rd_valid_o), 64'd0);
        check("rst_ovf", 64'(overflow_o), 64'd0);
        check("rst_trig", 64'(triggered_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);

        // FILL: drop once full
        mode_i = MODE_FILL; step();
        retire(32'h100, 6);
        check("fill_level", 64'(level_o), 64'd4);
        check("fill_ovf", 64'(overflow_o), 64'd1);
        check("fill_insn", 64'(rec.insn), 64'hA5A50100);
        check("fill_rd", 64'(rec.rd_addr), 64'd0);
        check("fill_wdata", 64'(rec.rd_wdata), 64'hFFFFFEFF);
        pop_expect("fill0", 32'h100);
        pop_expect("fill1", 32'h104);
        pop_expect("fill2", 32'h108);
        pop_expect("fill3", 32'h10C);
        check("fill_empty", 64'(rd_valid_o), 64'd0);
        check("fill_lvl0", 64'(level_o), 64'd0);
        do_clear();
        check("clr_ovf", 64'(overflow_o), 64'd0);

        // WRAP: keep newest
        mode_i = MODE_WRAP; step();
        retire(32'h100, 6);
        check("wrap_level", 64'(level_o), 64'd4);
        check("wrap_ovf", 64'(overflow_o), 64'd1);
        pop_expect("wrap0", 32'h108);
        pop_expect("wrap1", 32'h10C);
        pop_expect("wrap2", 32'h110);
        pop_expect("wrap3", 32'h114);
        check("wrap_empty", 64'(rd_valid_o), 64'd0);
        do_clear();

        // TRIG with two post-trigger records
        mode_i = MODE_TRIG; trig_pc_i = 32'h200; post_cnt_i = 3'd2; step();
        check("trig_armed_done", 64'(done_o), 64'd0);
        rvfi_valid_i = 1'b1;
        set_rec(32'h1F0); step();
        set_rec(32'h1F4); step();
        set_rec(32'h200); step();
        set_rec(32'h204); step();
        set_rec(32'h208); step();
        set_rec(32'h20C); step();
        rvfi_valid_i = 1'b0;
        check("trig_flag", 64'(triggered_o), 64'd1);
        check("trig_done", 64'(done_o), 64'd1);
        check("trig_level", 64'(level_o), 64'd4);
        pop_expect("trig0", 32'h1F4);
        pop_expect("trig1", 32'h200);
        pop_expect("trig2", 32'h204);
        pop_expect("trig3", 32'h208);
        check("trig_empty", 64'(rd_valid_o), 64'd0);
        do_clear();
        check("trig_clr_flag", 64'(triggered_o), 64'd0);
        check("trig_clr_done", 64'(done_o), 64'd0);

        // TRIG with zero post count: freeze right after the trigger record
        post_cnt_i = 3'd0; step();
        retire(32'h200, 1);
        check("t0_done", 64'(done_o), 64'd1);
        check("t0_level", 64'(level_o), 64'd1);
        retire(32'h204, 2);
        check("t0_level_hold", 64'(level_o), 64'd1);
        check("t0_done_hold", 64'(done_o), 64'd1);
        pop_expect("t0_rec", 32'h200);
        do_clear();

        // WRAP at full with continuous push and pop
        mode_i = MODE_WRAP; step();
        retire(32'h300, 4);
        check("pp_fill", 64'(level_o), 64'd4);
        rd_ready_i = 1'b1;
        rvfi_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("pp_pc", 64'(rec.pc), 64'(32'h300 + 32'(4 * i)));
            set_rec(32'h310 + 32'(4 * i));
            step();
            check("pp_level", 64'(level_o), 64'd4);
        end
        rvfi_valid_i = 1'b0; rd_ready_i = 1'b0;
        do_clear();
        check("pp_clr_level", 64'(level_o), 64'd0);

        // clear mid-capture at level 3, then the following cycle is IDLE
        mode_i = MODE_FILL; step();
        retire(32'h400, 5);
        pop_expect("mid_pop", 32'h400);
        check("mid_level3", 64'(level_o), 64'd3);
        check("mid_ovf", 64'(overflow_o), 64'd1);
        do_clear();
        check("clr3_level", 64'(level_o), 64'd0);
        check("clr3_valid", 64'(rd_valid_o), 64'd0);
        check("clr3_ovf", 64'(overflow_o), 64'd0);
        check("clr3_done", 64'(done_o), 64'd0);
        retire(32'h500, 1);
        check("clr3_idle", 64'(level_o), 64'd0);

        // synchronous reset mid-capture at level 3
        retire(32'h500, 5);
        pop_expect("rst_pop", 32'h500);
        check("rst_pre_level", 64'(level_o), 64'd3);
        rst_ni = 1'b0; step(); rst_ni = 1'b1;
        check("rst3_level", 64'(level_o), 64'd0);
        check("rst3_valid", 64'(rd_valid_o), 64'd0);
        check("rst3_ovf", 64'(overflow_o), 64'd0);
        retire(32'h600, 1);
        check("rst3_idle", 64'(level_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
